aes_enc_round_engine: RTL and testbench

- Iterative AES-128 encryption datapath sitting directly downstream of the round-key expansion unit.
- Accepts one 128-bit plaintext block over a valid/ready handshake and drives the key unit's load/restart/step strobes. It consumes one round key per round and returns the ciphertext over a valid/ready handshake.
- Processes one AES round per (1+KEY_SETTLE) clocks using 16 S-box instances for SubBytes, plus ShiftRows, MixColumns and AddRoundKey logic.

---
 rtl/aes_enc_round_engine.sv | 169 ++++++++++++++++
 tb/tb_aes_enc_round_engine.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_round_engine.sv
// rtl/aes_enc_round_engine.sv - iterative AES-128 encryption round engine
// Drives the external round-key unit with registered set/restart/step strobes.
module aes_enc_round_engine #(
  parameter int KEY_SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_set,
  output logic [127:0] key_master,
  output logic         key_restart,
  output logic         key_step,
  input  logic [127:0] round_key,
  input  logic         pt_valid,
  output logic         pt_ready,
  input  logic [127:0] pt_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic [127:0] ct_data,
  output logic         busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KLOAD = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_ARK   = 3'd3;
  localparam logic [2:0] S_ADV   = 3'd4;
  localparam logic [2:0] S_RND   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] SETTLE_M1 = 2'(KEY_SETTLE - 1);

  logic [2:0]   state;
  logic [127:0] st;
  logic [3:0]   rnd;
  logic [1:0]   cnt;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xt(aa);
    end
    return acc;
  endfunction

  // Inverse as x^254 (zero maps to zero), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    logic [7:0] v;
    p = gmul(x, x);
    r = p;
    for (int i = 0; i < 6; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    v = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]};
    return v ^ 8'h63;
  endfunction

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] rnd_out;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    end
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  assign rnd_out  = ((rnd == 4'd10) ? sr : mc) ^ round_key;
  assign pt_ready = (state == S_IDLE) && !key_load;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      st          <= '0;
      rnd         <= '0;
      cnt         <= '0;
      key_set     <= 1'b0;
      key_restart <= 1'b0;
      key_step    <= 1'b0;
      key_master  <= '0;
      ct_valid    <= 1'b0;
      ct_data     <= '0;
    end else begin
      key_set     <= 1'b0;
      key_restart <= 1'b0;
      key_step    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_load) begin
            key_master <= key_in;
            key_set    <= 1'b1;
            state      <= S_KLOAD;
          end else if (pt_valid) begin
            st          <= pt_data;
            key_restart <= 1'b1;
            cnt         <= SETTLE_M1;
            state       <= S_INIT;
          end
        end
        S_KLOAD: state <= S_IDLE;
        S_INIT: begin
          if (cnt == 2'd0) state <= S_ARK;
          else cnt <= cnt - 2'd1;
        end
        S_ARK: begin
          st       <= st ^ round_key;
          rnd      <= 4'd1;
          key_step <= 1'b1;
          cnt      <= SETTLE_M1;
          state    <= S_ADV;
        end
        S_ADV: begin
          if (cnt == 2'd0) state <= S_RND;
          else cnt <= cnt - 2'd1;
        end
        S_RND: begin
          st <= rnd_out;
          if (rnd != 4'd10) begin
            rnd      <= rnd + 4'd1;
            key_step <= 1'b1;
            cnt      <= SETTLE_M1;
            state    <= S_ADV;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the result; ct_data then stays frozen.
          if (!ct_valid) begin
            ct_valid <= 1'b1;
            ct_data  <= st;
          end else if (ct_ready) begin
            ct_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_round_engine.sv
// tb/tb_aes_enc_round_engine.sv - randomized self-checking bench with AES and key-unit models
module tb_aes_enc_round_engine;
  localparam int KS = 1;
  localparam int LAT = 2 + KS + 10 * (1 + KS);

  typedef logic [7:0] u8;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_set;
  logic [127:0] key_master;
  logic         key_restart;
  logic         key_step;
  logic [127:0] round_key;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  aes_enc_round_engine #(.KEY_SETTLE(KS)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_set(key_set),
    .key_master(key_master), .key_restart(key_restart), .key_step(key_step),
    .round_key(round_key), .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference AES: table S-box from the multiply-by-3 generator, byte-array rounds.
  u8 sbox_t[256];

  function automatic u8 rol8(input u8 v, input int n);
    logic [15:0] d;
    d = {v, v};
    return d[15-n -: 8];
  endfunction

  function automatic u8 xt(input u8 a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    u8 p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] rk_of(input logic [127:0] key, input int r);
    logic [31:0] w[44];
    logic [31:0] t;
    u8 rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    u8 s[16], t[16], a0, a1, a2, a3;
    logic [127:0] k, o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
        s = t;
        if (r < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
        end
      end
      k = rk_of(key, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Key-unit model: schedule installed on key_set, pointer follows restart/step.
  logic [127:0] sched[11];
  int kptr = 0;
  int set_n = 0, rst_n_cnt = 0, step_n = 0, excl_bad = 0;

  initial for (int r = 0; r < 11; r++) sched[r] = '0;

  assign round_key = (kptr < 11) ? sched[kptr] : '0;

  always @(posedge clk) begin
    if (key_set) for (int r = 0; r < 11; r++) sched[r] <= rk_of(key_master, r);
    if (key_restart) kptr <= 0;
    else if (key_step) kptr <= kptr + 1;
    set_n     <= set_n + int'(key_set);
    rst_n_cnt <= rst_n_cnt + int'(key_restart);
    step_n    <= step_n + int'(key_step);
    if (int'(key_set) + int'(key_restart) + int'(key_step) > 1) excl_bad <= excl_bad + 1;
  end

  task automatic load_key(input logic [127:0] k);
    int t;
    t = 0;
    key_in = k;
    key_load = 1'b1;
    while (!key_set && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("load_timeout", 128'd0, 128'd1);
    key_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pt(input logic [127:0] p);
    int t;
    t = 0;
    pt_data = p;
    pt_valid = 1'b1;
    while (!pt_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("accept_timeout", 128'd0, 128'd1);
    @(posedge clk);
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic get_ct(input int hold, output logic [127:0] ct, output int lat);
    int s0, s1, s2;
    lat = 0;
    while (!ct_valid && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 300) check("ct_timeout", 128'd0, 128'd1);
    ct = ct_data;
    s0 = set_n; s1 = rst_n_cnt; s2 = step_n;
    for (int i = 0; i < hold; i++) begin
      ct_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", 128'(ct_valid), 128'd1);
      check("hold_data", ct_data, ct);
      check("hold_ptready", 128'(pt_ready), 128'd0);
      check("hold_strobes", 128'({key_set, key_restart, key_step}), 128'd0);
    end
    if (hold > 0) check("hold_strobe_cnt", 128'(set_n + rst_n_cnt + step_n), 128'(s0 + s1 + s2));
    ct_ready = 1'b1;
    @(negedge clk);
    ct_ready = 1'b0;
    check("post_hs_valid", 128'(ct_valid), 128'd0);
    check("post_hs_idle", 128'(busy), 128'd0);
  endtask

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] ct, ct2, k2, p1, p2, c1;
    int lat, d_set, d_rst, d_step, t, bad, got_c1;
    build_sbox();
    rst = 1'b1; key_in = '0; key_load = 1'b0; pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pt_ready", 128'(pt_ready), 128'd1);
    check("rst_ct_valid", 128'(ct_valid), 128'd0);
    check("rst_ct_data", ct_data, 128'd0);
    check("rst_key_master", key_master, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_strobes", 128'({key_set, key_restart, key_step}), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 vector and latency
    load_key(C1K);
    send_pt(C1P);
    get_ct(0, ct, lat);
    check("c1_ct", ct, C1C);
    check("c1_latency", 128'(lat), 128'(LAT));

    // Appendix-B vector with strobe accounting
    d_set = set_n; d_rst = rst_n_cnt; d_step = step_n;
    load_key(BK);
    send_pt(BP);
    get_ct(0, ct, lat);
    check("b_ct", ct, BC);
    check("b_key_set_cnt", 128'(set_n - d_set), 128'd1);
    check("b_restart_cnt", 128'(rst_n_cnt - d_rst), 128'd1);
    check("b_step_cnt", 128'(step_n - d_step), 128'd10);

    // Back-to-back replay with the same key
    d_rst = rst_n_cnt; d_step = step_n;
    send_pt(BP);
    get_ct(0, ct, lat);
    send_pt(BP);
    get_ct(0, ct2, lat);
    check("b2b_first", ct, BC);
    check("b2b_second", ct2, ct);
    check("b2b_restart_cnt", 128'(rst_n_cnt - d_rst), 128'd2);
    check("b2b_step_cnt", 128'(step_n - d_step), 128'd20);

    // Downstream stall for 50 clocks
    send_pt(BP);
    get_ct(50, ct, lat);
    check("stall_ct", ct, BC);

    // Reset during round 5
    load_key(C1K);
    d_step = step_n;
    send_pt(C1P);
    t = 0;
    while (step_n < d_step + 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("r5_timeout", 128'd0, 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_pt_ready", 128'(pt_ready), 128'd1);
    check("mid_rst_ct_valid", 128'(ct_valid), 128'd0);
    check("mid_rst_ct_data", ct_data, 128'd0);
    check("mid_rst_key_master", key_master, 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_strobes", 128'({key_set, key_restart, key_step}), 128'd0);
    d_rst = rst_n_cnt; bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (ct_valid || busy) bad++;
    end
    check("mid_rst_quiet", 128'(bad), 128'd0);
    check("mid_rst_no_restart", 128'(rst_n_cnt - d_rst), 128'd0);
    load_key(C1K);
    send_pt(C1P);
    get_ct(0, ct, lat);
    check("after_rst_ct", ct, C1C);

    // key_load during round 3, held, with simultaneous pt_valid on return to IDLE
    k2 = {$urandom, $urandom, $urandom, $urandom};
    p1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    d_step = step_n;
    send_pt(p1);
    t = 0;
    while (step_n < d_step + 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    d_set = set_n; bad = 0; got_c1 = 0; c1 = '0;
    key_in = k2; key_load = 1'b1; pt_data = p2; pt_valid = 1'b1; ct_ready = 1'b1;
    t = 0;
    while (busy && t < 300) begin
      if (ct_valid) begin
        c1 = ct_data;
        got_c1 = 1;
      end
      if (key_set || set_n != d_set) bad++;
      @(negedge clk);
      t++;
    end
    ct_ready = 1'b0;
    check("kl_mid_block_ignored", 128'(bad), 128'd0);
    check("kl_first_ct_seen", 128'(got_c1), 128'd1);
    check("kl_first_ct", c1, aes_ref(C1K, p1));
    check("kl_priority_pt_ready", 128'(pt_ready), 128'd0);
    check("kl_master_unchanged", key_master, C1K);
    @(negedge clk);
    check("kl_key_set", 128'(key_set), 128'd1);
    check("kl_master_new", key_master, k2);
    key_load = 1'b0;
    send_pt(p2);
    get_ct(0, ct, lat);
    check("kl_second_ct", ct, aes_ref(k2, p2));
    check("kl_latency", 128'(lat), 128'(LAT));

    // Randomized keys, plaintexts and short stalls
    for (int n = 0; n < 5; n++) begin
      k2 = {$urandom, $urandom, $urandom, $urandom};
      p2 = {$urandom, $urandom, $urandom, $urandom};
      load_key(k2);
      send_pt(p2);
      get_ct(int'($urandom_range(0, 3)), ct, lat);
      check("rand_ct", ct, aes_ref(k2, p2));
    end

    check("strobe_exclusive", 128'(excl_bad), 128'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
